// File: rtl/alu_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : alu_display_scan
// Description : Two-digit 7-segment scanner for the 3-bit ALU result.
//               Shows BCD tens/units with leading-zero blanking, a dash for
//               non-BCD codes, and a blinking "Er" when the ALU reports an
//               error. Inputs are latched once per refresh frame so a digit
//               pair is never split across two different results.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_display_scan #(
    parameter int CLK_DIV      = 4096,  // clock cycles per digit slot (>= 2)
    parameter int BLINK_FRAMES = 32     // refresh frames per blink half-period (>= 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       zero,
    input  logic       error,
    output logic [6:0] seg,
    output logic [3:0] digit_sel,
    output logic       zero_led
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_PRE_W = $clog2(CLK_DIV);
    localparam int C_BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(CLK_DIV - 1);
    localparam logic [C_BLK_W-1:0] C_BLK_MAX = C_BLK_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] C_SEG_OFF  = 7'h00;
    localparam logic [6:0] C_SEG_DASH = 7'h40;
    localparam logic [6:0] C_SEG_E    = 7'h79;
    localparam logic [6:0] C_SEG_R    = 7'h50;

    localparam logic [3:0] C_SEL_NONE  = 4'b1111;
    localparam logic [3:0] C_SEL_UNITS = 4'b1110;
    localparam logic [3:0] C_SEL_TENS  = 4'b1101;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_UNITS = 2'd1,
        ST_TENS  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // BCD to 7-segment glyph; anything above 9 renders as a dash
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] v;
        case (d)
            4'd0:    v = 7'h3F;
            4'd1:    v = 7'h06;
            4'd2:    v = 7'h5B;
            4'd3:    v = 7'h4F;
            4'd4:    v = 7'h66;
            4'd5:    v = 7'h6D;
            4'd6:    v = 7'h7D;
            4'd7:    v = 7'h07;
            4'd8:    v = 7'h7F;
            4'd9:    v = 7'h6F;
            default: v = C_SEG_DASH;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [C_PRE_W-1:0] r_pre;
    logic [C_BLK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [3:0]         r_snap_tens;
    logic               r_snap_error;

    logic               w_tick;
    logic               w_frame;
    logic [C_BLK_W-1:0] w_blink_cnt_nxt;
    logic               w_blink_phase_nxt;
    logic [6:0]         w_units_seg;
    logic [6:0]         w_tens_seg;

    assign w_tick = (r_pre == C_PRE_MAX);

    // A frame starts on every entry to the UNITS slot, including the first
    // one out of BLANK after reset.
    assign w_frame = w_tick && ((r_state == ST_BLANK) || (r_state == ST_TENS));

    // Slot-rate prescaler, free-running 0..CLK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Blink state that will hold after the current frame boundary. A rising
    // error (live high, snapshot low) restarts the half-period with the glyphs
    // visible so the message appears without delay.
    always_comb begin
        w_blink_cnt_nxt   = r_blink_cnt;
        w_blink_phase_nxt = r_blink_phase;
        if (!error || !r_snap_error) begin
            w_blink_cnt_nxt   = '0;
            w_blink_phase_nxt = 1'b1;
        end else if (r_blink_cnt == C_BLK_MAX) begin
            w_blink_cnt_nxt   = '0;
            w_blink_phase_nxt = ~r_blink_phase;
        end else begin
            w_blink_cnt_nxt   = r_blink_cnt + 1'b1;
        end
    end

    // Glyphs for the slot being entered. The units glyph is built from the
    // live inputs because it is loaded on the same edge the snapshot is taken;
    // the tens glyph comes from the snapshot so mid-frame changes cannot leak.
    always_comb begin
        w_units_seg = f_decode(units);
        if (error) begin
            w_units_seg = w_blink_phase_nxt ? C_SEG_R : C_SEG_OFF;
        end

        w_tens_seg = f_decode(r_snap_tens);
        if (r_snap_error) begin
            w_tens_seg = r_blink_phase ? C_SEG_E : C_SEG_OFF;
        end else if (r_snap_tens == 4'd0) begin
            w_tens_seg = C_SEG_OFF;
        end
    end

    // Per-frame snapshot and blink bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_tens   <= 4'd0;
            r_snap_error  <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame) begin
            r_snap_tens   <= tens;
            r_snap_error  <= error;
            r_blink_cnt   <= w_blink_cnt_nxt;
            r_blink_phase <= w_blink_phase_nxt;
        end
    end

    // Scan FSM with registered segment, digit-enable and zero outputs; the
    // old and new digit enables swap on the same edge so they never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_BLANK;
            seg       <= C_SEG_OFF;
            digit_sel <= C_SEL_NONE;
            zero_led  <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                ST_BLANK, ST_TENS: begin
                    r_state   <= ST_UNITS;
                    seg       <= w_units_seg;
                    digit_sel <= C_SEL_UNITS;
                    zero_led  <= zero;
                end
                ST_UNITS: begin
                    r_state   <= ST_TENS;
                    seg       <= w_tens_seg;
                    digit_sel <= C_SEL_TENS;
                end
                default: begin
                    r_state   <= ST_BLANK;
                    seg       <= C_SEG_OFF;
                    digit_sel <= C_SEL_NONE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_display_scan
// Description : Directed self-checking bench for alu_display_scan with
//               CLK_DIV=4 and BLINK_FRAMES=2. Inputs change and outputs are
//               sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_display_scan;

    localparam logic [3:0] SEL_N = 4'hF;
    localparam logic [3:0] SEL_U = 4'hE;
    localparam logic [3:0] SEL_T = 4'hD;

    logic       clk;
    logic       rst;
    logic [3:0] tens;
    logic [3:0] units;
    logic       zero;
    logic       error;
    logic [6:0] seg;
    logic [3:0] digit_sel;
    logic       zero_led;

    int n_checks = 0;
    int n_errors = 0;

    alu_display_scan #(
        .CLK_DIV      (4),
        .BLINK_FRAMES (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .tens      (tens),
        .units     (units),
        .zero      (zero),
        .error     (error),
        .seg       (seg),
        .digit_sel (digit_sel),
        .zero_led  (zero_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Check n consecutive cycles of one slot, advancing one cycle per sample
    task automatic slot(input string tag, input logic [3:0] sel, input logic [6:0] sg,
                        input logic zl, input int n);
        for (int i = 0; i < n; i++) begin
            check_val({tag, "/sel"}, 8'(digit_sel), 8'(sel));
            check_val({tag, "/seg"}, 8'(seg), 8'(sg));
            check_val({tag, "/zled"}, 8'(zero_led), 8'(zl));
            @(negedge clk);
        end
    endtask

    // One full frame: UNITS slot then TENS slot
    task automatic frame(input string tag, input logic [6:0] u_seg, input logic [6:0] t_seg,
                         input logic zl);
        slot({tag, "/u"}, SEL_U, u_seg, zl, 4);
        slot({tag, "/t"}, SEL_T, t_seg, zl, 4);
    endtask

    initial begin
        rst   = 1'b1;
        tens  = 4'd4;
        units = 4'd2;
        zero  = 1'b0;
        error = 1'b0;

        // Held in reset
        repeat (3) @(negedge clk);
        slot("reset_hold", SEL_N, 7'h00, 1'b0, 2);

        // Release: four blank cycles, then the UNITS slot of 42
        rst = 1'b0;
        @(negedge clk);
        slot("post_rst_blank", SEL_N, 7'h00, 1'b0, 3);
        frame("two_digit_f0", 7'h5B, 7'h66, 1'b0);
        frame("two_digit_f1", 7'h5B, 7'h66, 1'b0);

        // Leading-zero blank and zero flag; current frame still shows 42
        tens = 4'd0; units = 4'd0; zero = 1'b1;
        frame("zero_prev", 7'h5B, 7'h66, 1'b0);
        frame("zero_f0", 7'h3F, 7'h00, 1'b1);

        // Anti-tear: value changes two cycles into UNITS
        tens = 4'd1; units = 4'd1; zero = 1'b0;
        frame("tear_prev", 7'h3F, 7'h00, 1'b1);
        slot("tear_u_a", SEL_U, 7'h06, 1'b0, 2);
        tens = 4'd7; units = 4'd8;
        slot("tear_u_b", SEL_U, 7'h06, 1'b0, 2);
        slot("tear_t", SEL_T, 7'h06, 1'b0, 4);
        frame("tear_next", 7'h7F, 7'h07, 1'b0);

        // Non-BCD codes render as dashes
        tens = 4'd10; units = 4'd12;
        frame("bcd_prev", 7'h7F, 7'h07, 1'b0);
        frame("bcd_dash", 7'h40, 7'h40, 1'b0);

        // Error with zero also set: "Er" for 2 frames, dark for 2, back on
        error = 1'b1; zero = 1'b1;
        frame("err_prev", 7'h40, 7'h40, 1'b0);
        frame("err_f0", 7'h50, 7'h79, 1'b1);
        frame("err_f1", 7'h50, 7'h79, 1'b1);
        frame("err_f2", 7'h00, 7'h00, 1'b1);
        frame("err_f3", 7'h00, 7'h00, 1'b1);
        error = 1'b0; tens = 4'd4; units = 4'd2;
        frame("err_f4", 7'h50, 7'h79, 1'b1);
        frame("err_clear", 7'h5B, 7'h66, 1'b1);

        // Asynchronous reset in the middle of a TENS slot
        slot("mid_u", SEL_U, 7'h5B, 1'b1, 4);
        slot("mid_t", SEL_T, 7'h66, 1'b1, 2);
        rst = 1'b1;
        #1;
        check_val("async_rst/seg", 8'(seg), 8'h00);
        check_val("async_rst/sel", 8'(digit_sel), 8'(SEL_N));
        check_val("async_rst/zled", 8'(zero_led), 8'h00);
        @(negedge clk);
        slot("rst2_hold", SEL_N, 7'h00, 1'b0, 2);
        rst = 1'b0;
        @(negedge clk);
        slot("rst2_blank", SEL_N, 7'h00, 1'b0, 3);
        frame("rst2_f0", 7'h5B, 7'h66, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_display_scan.md
# alu_display_scan

Downstream display stage for the 3-bit ALU. Consumes the ALU's BCD tens/units digits and its zero/error flags, and time-multiplexes them onto two digits of a common-segment 7-segment display. Values are snapshotted once per refresh frame to prevent tearing. Tens digits of 0 are blanked, non-BCD codes show a dash, and error is shown as a blinking "Er".

## Interface
- CLK_DIV, 4096, clock cycles per digit slot (≥2)
- BLINK_FRAMES, 32, refresh frames per blink half-period (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tens  in  4  BCD tens digit from ALU
- units  in  4  BCD units digit from ALU
- zero  in  1  ALU result-is-zero flag
- error  in  1  ALU error flag
- seg  out  7  segments, active-high, seg[0]=a … seg[6]=g
- digit_sel  out  4  digit enables, active-low: [0]=units, [1]=tens, [3:2] always 1
- zero_led  out  1  registered zero flag of current snapshot

One clock; reset is asynchronous and active-high. All outputs are registered.

## Operation
- Prescaler: counts 0..CLK_DIV-1 and wraps. `tick` is asserted when count==CLK_DIV-1.
- FSM states: BLANK (reset state), UNITS, TENS. The FSM changes only on `tick`.
  - BLANK→UNITS
  - UNITS→TENS
  - TENS→UNITS
- Frame boundary = every entry to UNITS, including from BLANK.
  - On that edge, snapshot {tens, units, zero, error} from the live inputs.
  - Drive seg from the live inputs on that same edge; do not use the stale snapshot.
- Outputs per state:
  - BLANK: digit_sel=4'b1111, seg=0.
  - UNITS: digit_sel=4'b1110, seg=decode(snap_units).
  - TENS: digit_sel=4'b1101, seg=decode(snap_tens). If snap_tens==0, seg=0 (leading-zero blank).
- Decode (hex):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 show '-' = 40.
  - Units 0 is always shown, so a zero result displays as a single "0".
- Error mode (snap_error=1) overrides digits:
  - blink_phase=1: tens shows 'E'=79, units shows 'r'=50.
  - blink_phase=0: seg=0 in both slots; digit_sel keeps scanning.
- Blink counter:
  - Counts frame boundaries 0..BLINK_FRAMES-1. On wrap it toggles blink_phase.
  - When snap_error goes 0→1 at a frame boundary, the counter is cleared and blink_phase=1, so "Er" appears immediately.
  - While snap_error=0, the counter is held at 0 and blink_phase=1.
- zero_led: updated to the live zero on each frame boundary.

## Timing
- Reset values: state=BLANK, prescaler=0, snapshot=0, blink_phase=1, blink counter=0, seg=7'h00, digit_sel=4'hF, zero_led=0.
- First visible digit: UNITS, on the clock edge where the prescaler reaches CLK_DIV-1 after reset release, i.e. CLK_DIV cycles after reset deasserts.
- Each digit is held for exactly CLK_DIV cycles. A frame is 2·CLK_DIV cycles.
- Input latency:
  - A change is displayed at the next frame boundary.
  - Worst case is 2·CLK_DIV cycles when the input changes just after a boundary.
  - Input changes mid-frame never alter the TENS slot of the current frame.
- Inputs are sampled only on frame-boundary edges; they need be stable only at those edges.
- Blink half-period is BLINK_FRAMES·2·CLK_DIV cycles.
- Reset mid-frame or mid-blink: all outputs return to reset values asynchronously. After release, the sequence restarts from BLANK.
- Simultaneous error and zero: error display wins; zero_led still follows snap_zero.
- Digit_sel never enables two digits at once. On every transition the old and new digit change on the same edge (no overlap).

## Test plan
Tests use CLK_DIV=4, BLINK_FRAMES=2.
- **Reset:** assert rst mid-TENS.
  - seg=00, digit_sel=F, zero_led=0 without waiting for a clock edge.
  - After release, 4 cycles of blank, then digit_sel=E.
- **Two-digit value:** tens=4, units=2, error=0.
  - Repeating pattern: 4 cycles with digit_sel=E, seg=5B; then 4 cycles with digit_sel=D, seg=66.
- **Leading-zero blank and zero:** tens=0, units=0, zero=1.
  - UNITS slot seg=3F, TENS slot seg=00, zero_led=1 from the first frame boundary.
- **Anti-tear:** tens=1, units=1; change to tens=7, units=8 two cycles into UNITS.
  - The current TENS slot still shows 06.
  - The next frame shows 7F then 07.
- **Invalid BCD:** units=12, tens=10.
  - UNITS and TENS slots both show seg=40.
- **Error blink:** error=1 at a frame boundary.
  - The UNITS slot of that same frame shows 50 and the TENS slot shows 79.
  - After 2 frames both slots show seg=00 for 2 frames, then "Er" returns.
  - Dropping error to 0 restores digits at the next boundary.
